// File: rtl/idli_sqi_ctrl_m.sv
// Shared SQI memory sequencer: arbitrates fetch vs load/store and runs the
// command/address/dummy/data/deselect phases on the nibble-wide SIO bus.
module idli_sqi_ctrl_m #(
  parameter logic [7:0] CMD_RD       = 8'h03,
  parameter logic [7:0] CMD_WR       = 8'h02,
  parameter int         DUMMY_CYCLES = 2,
  parameter int         DESEL_CYCLES = 1
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_fetch_req,
  input  logic [15:0] i_sqi_fetch_addr,
  output logic        o_sqi_fetch_gnt,
  output logic        o_sqi_fetch_vld,
  input  logic        i_sqi_mem_req,
  input  logic        i_sqi_mem_wr,
  input  logic [15:0] i_sqi_mem_addr,
  input  logic [15:0] i_sqi_mem_wdata,
  output logic        o_sqi_mem_gnt,
  output logic        o_sqi_mem_vld,
  output logic        o_sqi_mem_done,
  output logic [3:0]  o_sqi_rd_data,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sio_oe,
  output logic [3:0]  o_sqi_sio_out,
  input  logic [3:0]  i_sqi_sio_in
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DESEL = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [2:0]  phase, phase_max;
  logic        phase_end;
  logic [15:0] addr_q, wdata_q;
  logic        wr_q;
  logic        owner_q;   // 1 = load/store owns the transfer
  logic        last_gnt;  // 1 = load/store was granted last
  logic        fetch_win, mem_win;
  logic [7:0]  cmd;

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
    logic [3:0] r;
    case (i)
      2'd0:    r = w[15:12];
      2'd1:    r = w[11:8];
      2'd2:    r = w[7:4];
      default: r = w[3:0];
    endcase
    return r;
  endfunction

  // Only arbitrate while idle; on contention the requester not granted last wins.
  always_comb begin
    fetch_win = 1'b0;
    mem_win   = 1'b0;
    if (state == S_IDLE) begin
      fetch_win = i_sqi_fetch_req && (!i_sqi_mem_req || last_gnt);
      mem_win   = i_sqi_mem_req && (!i_sqi_fetch_req || !last_gnt);
    end
  end

  assign o_sqi_fetch_gnt = fetch_win;
  assign o_sqi_mem_gnt   = mem_win;

  always_comb begin
    phase_max = 3'd0;
    case (state)
      S_CMD:   phase_max = 3'd1;
      S_ADDR:  phase_max = 3'd3;
      S_DUMMY: phase_max = 3'(DUMMY_CYCLES - 1);
      S_DATA:  phase_max = 3'd3;
      S_DESEL: phase_max = 3'(DESEL_CYCLES - 1);
      default: phase_max = 3'd0;
    endcase
  end

  assign phase_end = (phase == phase_max);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch_win || mem_win) state_nxt = S_CMD;
      S_CMD:   if (phase_end) state_nxt = S_ADDR;
      S_ADDR:  if (phase_end) state_nxt = wr_q ? S_DATA : S_DUMMY;
      S_DUMMY: if (phase_end) state_nxt = S_DATA;
      S_DATA:  if (phase_end) state_nxt = S_DESEL;
      S_DESEL: if (phase_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state <= S_IDLE;
      phase <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == S_IDLE) phase <= 3'd0;
      else                                       phase <= phase + 3'd1;
    end
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      addr_q   <= 16'h0;
      wdata_q  <= 16'h0;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_gnt <= 1'b1;
    end else if (fetch_win) begin
      addr_q   <= i_sqi_fetch_addr;
      wr_q     <= 1'b0;
      owner_q  <= 1'b0;
      last_gnt <= 1'b0;
    end else if (mem_win) begin
      addr_q   <= i_sqi_mem_addr;
      wdata_q  <= i_sqi_mem_wdata;
      wr_q     <= i_sqi_mem_wr;
      owner_q  <= 1'b1;
      last_gnt <= 1'b1;
    end
  end

  // Read nibbles are captured in DATA and presented one cycle later with vld.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      o_sqi_rd_data   <= 4'h0;
      o_sqi_fetch_vld <= 1'b0;
      o_sqi_mem_vld   <= 1'b0;
      o_sqi_mem_done  <= 1'b0;
    end else begin
      if (state == S_DATA && !wr_q) o_sqi_rd_data <= i_sqi_sio_in;
      o_sqi_fetch_vld <= (state == S_DATA) && !wr_q && !owner_q;
      o_sqi_mem_vld   <= (state == S_DATA) && !wr_q && owner_q;
      o_sqi_mem_done  <= (state == S_DATA) && wr_q && phase_end;
    end
  end

  assign cmd          = wr_q ? CMD_WR : CMD_RD;
  assign o_sqi_cs_n   = !(state == S_CMD || state == S_ADDR || state == S_DUMMY || state == S_DATA);
  assign o_sqi_sio_oe = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA && wr_q);

  always_comb begin
    o_sqi_sio_out = 4'h0;
    case (state)
      S_CMD:   o_sqi_sio_out = phase[0] ? cmd[3:0] : cmd[7:4];
      S_ADDR:  o_sqi_sio_out = nib(addr_q, phase[1:0]);
      S_DATA:  o_sqi_sio_out = wr_q ? nib(wdata_q, phase[1:0]) : 4'h0;
      default: o_sqi_sio_out = 4'h0;
    endcase
  end

endmodule
